// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared constants and types for the 16-bit Hamming decoder
//               (codeword layout, Hamming positions, parity-group masks).
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 21;
    localparam int SYN_W  = 5;

    // Hamming position of d0..d15; parity bits occupy the powers of two
    localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
    };

    // Data bits covered by p0..p4
    localparam logic [DATA_W-1:0] P_MASK [SYN_W] = '{
        16'hAD5B, 16'h366D, 16'hC78E, 16'h07F0, 16'hF800
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syndrome;
        logic              corrected;
        logic              uncorrectable;
    } dec_word_t;

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
// Module      : hamming_syndrome
// Description : Combinational syndrome {s4..s0} of a 21-bit Hamming codeword.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] ham_in,
    output logic [SYN_W-1:0]  syndrome
);

    logic [DATA_W-1:0] w_data;

    assign w_data = ham_in[CODE_W-1:SYN_W];

    // pK sits at ham_in[4-K]
    for (genvar k = 0; k < SYN_W; k++) begin : g_syn
        assign syndrome[k] = (^(w_data & P_MASK[k])) ^ ham_in[SYN_W-1-k];
    end

endmodule
`default_nettype wire

// File: rtl/hamming_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_decoder
// Description : Two-stage valid/ready single-error-correcting decoder for
//               21-bit codewords, with saturating corrected/uncorrectable counts.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] ham_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome_out,
    output logic              corrected,
    output logic              uncorrectable,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  unc_cnt
);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [SYN_W-1:0]  r_s1_syn;
    logic              r_out_valid;
    dec_word_t         r_out;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_unc_cnt;

    logic [SYN_W-1:0]  w_syn;
    logic              w_s1_en;
    logic              w_s2_en;
    logic              w_xfer;
    dec_word_t         w_dec;

    hamming_syndrome u_syndrome (
        .ham_in   (ham_in),
        .syndrome (w_syn)
    );

    assign w_s2_en = !r_out_valid || out_ready;
    assign w_s1_en = !r_s1_valid || w_s2_en;
    assign w_xfer  = r_out_valid && out_ready;

    // Syndromes 1..21 all name a real bit; only data positions need a flip
    always_comb begin
        w_dec.data          = r_s1_data;
        w_dec.syndrome      = r_s1_syn;
        w_dec.uncorrectable = (r_s1_syn > SYN_W'(CODE_W));
        w_dec.corrected     = (r_s1_syn != '0) && (r_s1_syn <= SYN_W'(CODE_W));
        for (int i = 0; i < DATA_W; i++) begin
            if (r_s1_syn == DATA_POS[i]) begin
                w_dec.data[i] = ~r_s1_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_syn    <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            // Parity bits are dead once the syndrome is captured
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= ham_in[CODE_W-1:SYN_W];
                    r_s1_syn  <= w_syn;
                end
            end
            if (w_s2_en) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out <= w_dec;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else begin
            if (w_xfer && r_out.corrected && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (w_xfer && r_out.uncorrectable && (r_unc_cnt != '1)) begin
                r_unc_cnt <= r_unc_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready      = w_s1_en;
    assign out_valid     = r_out_valid;
    assign data_out      = r_out.data;
    assign syndrome_out  = r_out.syndrome;
    assign corrected     = r_out.corrected;
    assign uncorrectable = r_out.uncorrectable;
    assign corr_cnt      = r_corr_cnt;
    assign unc_cnt       = r_unc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_decoder
// Description : Self-checking bench for hamming_decoder (CNT_W=16 and CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        clr_cnt;
    logic [20:0] ham_in;

    logic        in_ready, out_valid, corrected, uncorrectable;
    logic [15:0] data_out;
    logic [4:0]  syndrome_out;
    logic [15:0] corr_cnt, unc_cnt;

    logic        s_in_ready, s_out_valid, s_corrected, s_uncorrectable;
    logic [15:0] s_data_out;
    logic [4:0]  s_syndrome_out;
    logic [1:0]  s_corr_cnt, s_unc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int DPOS [16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

    always #5 clk = ~clk;

    hamming_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ham_in(ham_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .syndrome_out(syndrome_out), .corrected(corrected), .uncorrectable(uncorrectable),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .unc_cnt(unc_cnt)
    );

    hamming_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .ham_in(ham_in),
        .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
        .syndrome_out(s_syndrome_out), .corrected(s_corrected), .uncorrectable(s_uncorrectable),
        .clr_cnt(clr_cnt), .corr_cnt(s_corr_cnt), .unc_cnt(s_unc_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: place every bit at its Hamming position, XOR the positions of set bits
    function automatic logic [22:0] model_decode(input logic [20:0] cw);
        logic [21:0] v;
        logic [15:0] d;
        int          syn;
        logic        c, u;
        v = '0;
        for (int i = 0; i < 16; i++) v[DPOS[i]] = cw[5+i];
        for (int k = 0; k < 5; k++) v[1 << k] = cw[4-k];
        syn = 0;
        for (int p = 1; p <= 21; p++) if (v[p]) syn = syn ^ p;
        c = (syn >= 1) && (syn <= 21);
        u = (syn > 21);
        if (c) v[syn] = ~v[syn];
        for (int i = 0; i < 16; i++) d[i] = v[DPOS[i]];
        return {u, c, 5'(syn), d};
    endfunction

    function automatic int sat(input int m, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (m > lim) ? lim : m;
    endfunction

    // Scoreboard / compare process: {unc, corr, syn, data}
    logic [22:0] exp_q[$];
    int          m_corr = 0;
    int          m_unc  = 0;
    bit          stalled = 1'b0;
    logic [22:0] held;

    always @(negedge clk) begin
        logic [22:0] e;
        logic [22:0] now;
        now = {uncorrectable, corrected, syndrome_out, data_out};
        e   = '0;
        if (rst) begin
            exp_q.delete();
            m_corr  = 0;
            m_unc   = 0;
            stalled = 1'b0;
        end else begin
            check("corr_cnt16", 32'(corr_cnt), sat(m_corr, 16));
            check("unc_cnt16", 32'(unc_cnt), sat(m_unc, 16));
            check("corr_cnt2", 32'(s_corr_cnt), sat(m_corr, 2));
            check("unc_cnt2", 32'(s_unc_cnt), sat(m_unc, 2));
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_payload", 32'(now), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", now);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'(now), 32'(e));
                end
            end
            if (clr_cnt) begin
                m_corr = 0;
                m_unc  = 0;
            end else begin
                if (e[21]) m_corr++;
                if (e[22]) m_unc++;
            end
            stalled = out_valid && !out_ready;
            held    = now;
            if (in_valid && in_ready) exp_q.push_back(model_decode(ham_in));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [20:0] cw);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        ham_in   = cw;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [15:0] d, input logic [4:0] s,
                               input logic c, input logic u);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got out_valid=0, expected 1 within 20 cycles", name);
        end else begin
            check({name, "_data"}, 32'(data_out), 32'(d));
            check({name, "_syn"}, 32'(syndrome_out), 32'(s));
            check({name, "_corr"}, 32'(corrected), 32'(c));
            check({name, "_unc"}, 32'(uncorrectable), 32'(u));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_check(input string name, input int c16, input int u16, input int c2, input int u2);
        @(negedge clk);
        check({name, "_corr16"}, 32'(corr_cnt), c16);
        check({name, "_unc16"}, 32'(unc_cnt), u16);
        check({name, "_corr2"}, 32'(s_corr_cnt), c2);
        check({name, "_unc2"}, 32'(s_unc_cnt), u2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] sw [4];
        int idx, acc;
        bit took;
        sw[0] = 21'h1FFFCF;   // 0xFFFF with d0 flipped
        sw[1] = 21'h000000;
        sw[2] = 21'h1FFFEF;
        sw[3] = 21'h000001;   // p4 flipped

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; ham_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_syn", 32'(syndrome_out), 0);
        check("rst_flags", 32'({corrected, uncorrectable}), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Back-to-back clean words, latency and throughput
        @(posedge clk); #1;
        in_valid = 1'b1; ham_in = 21'h000000;
        @(posedge clk); #1;
        ham_in = 21'h1FFFEF;
        @(negedge clk);
        check("lat_e1_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_e2_valid", 32'(out_valid), 1);
        check("lat_e2_data", 32'(data_out), 32'h0000);
        check("lat_e2_syn", 32'(syndrome_out), 0);
        check("lat_e2_flags", 32'({corrected, uncorrectable}), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_e3_valid", 32'(out_valid), 1);
        check("lat_e3_data", 32'(data_out), 32'hFFFF);
        check("lat_e3_syn", 32'(syndrome_out), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_e4_valid", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Single and double errors
        send(21'h000020);
        expect_word("d0_flip", 16'h0000, 5'd3, 1'b1, 1'b0);
        cnt_check("after_d0", 1, 0, 1, 0);
        send(21'h1FFFFF);
        expect_word("p0_flip", 16'hFFFF, 5'd1, 1'b1, 1'b0);
        cnt_check("after_p0", 2, 0, 2, 0);
        send(21'h100020);
        expect_word("double", 16'h8001, 5'd22, 1'b0, 1'b1);
        cnt_check("after_double", 2, 1, 2, 1);

        // Stall with output held off for five cycles
        out_ready = 1'b0;
        idx = 0; acc = 0;
        in_valid = 1'b1; ham_in = sw[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                idx++;
                ham_in = sw[idx];
            end
        end
        check("stall_accepted", acc, 2);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_out_valid", 32'(out_valid), 1);
        check("stall_data", 32'(data_out), 32'hFFFF);
        check("stall_syn", 32'(syndrome_out), 3);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = idx; i < 4; i++) send(sw[i]);
        repeat (4) @(posedge clk);
        #1;
        cnt_check("after_stall", 4, 1, 3, 1);

        // Saturation of the 2-bit counter
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        cnt_check("after_clr", 0, 0, 0, 0);
        repeat (5) send(21'h000020);
        repeat (4) @(posedge clk);
        #1;
        cnt_check("after_sat", 5, 0, 3, 0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(21'h000020);
        send(21'h100020);
        @(negedge clk);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_corr_cnt", 32'(corr_cnt), 0);
        check("midrst_unc_cnt", 32'(unc_cnt), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Clear coinciding with a corrected transfer
        send(21'h000020);
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(negedge clk);
        check("clr_coincide_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        cnt_check("clr_wins", 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_decoder.md
# hamming_decoder

Receive-side stage directly downstream of the 16-bit Hamming encoder. It accepts 21-bit codewords in the encoder's layout, recomputes parity, and corrects any single-bit error. It delivers 16-bit data with status flags over a two-stage valid/ready pipeline, and keeps saturating counts of corrected and uncorrectable words for system monitoring.

## Interface
- CNT_W, 16, width of each error counter (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  codeword present
- in_ready  out  1  decoder accepts codeword this cycle
- ham_in  in  21  codeword: [20:5]=data[15:0], [4]=p0, [3]=p1, [2]=p2, [1]=p3, [0]=p4
- out_valid  out  1  decoded word present
- out_ready  in  1  consumer accepts
- data_out  out  16  corrected data
- syndrome_out  out  5  {s4,s3,s2,s1,s0}; 0 = clean
- corrected  out  1  single-bit error fixed
- uncorrectable  out  1  syndrome 22..31; data_out = raw received data
- clr_cnt  in  1  synchronous counter clear
- corr_cnt  out  CNT_W  corrected-word count, saturating
- unc_cnt  out  CNT_W  uncorrectable-word count, saturating

## Operation
- Parity groups are identical to the encoder's:
  - p0: d0,1,3,4,6,8,10,11,13,15
  - p1: d0,2,3,5,6,9,10,12,13
  - p2: d1,2,3,7,8,9,10,14,15
  - p3: d4..d10
  - p4: d11..d15
- sK = recomputed pK XOR received pK. The syndrome value is the Hamming position of the flipped bit.
- Parity positions: 1=p0, 2=p1, 4=p2, 8=p3, 16=p4.
- Data positions, d0..d15 in order: 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21.
- Syndrome 0: data passes through; corrected=0, uncorrectable=0.
- Syndrome at a data position: invert that data bit; corrected=1.
- Syndrome at a parity position: data is unchanged; corrected=1.
- Syndrome 22..31: data is unchanged; uncorrectable=1.
- There is no overall parity bit. Double errors whose syndrome is ≤21 alias to a miscorrection. This is accepted and documented; it is not detected.
- Counters increment on an output transfer (out_valid & out_ready) with the matching flag set, and hold at 2^CNT_W−1.
- clr_cnt zeroes both counters. If clear and increment occur in the same cycle, clear wins and that event is not counted.

## Timing
- Stage 1 registers ham_in and the syndrome. Stage 2 registers data_out, syndrome_out and the flags.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Full throughput is 1 word/clk.
- Enables:
  - s2_en = !out_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en. This is a combinational path from out_ready; there is no skid buffer.
- Handshake rules:
  - While out_valid=1 and out_ready=0, data_out, syndrome_out and the flags hold stable.
  - in_valid=1 with in_ready=0 must be held stable by the producer.
- Reset values:
  - out_valid=0, s1_valid=0
  - data_out=0, syndrome_out=0, corrected=0, uncorrectable=0
  - corr_cnt=0, unc_cnt=0
  - in_ready=1 in the first cycle after reset
- Reset mid-stream discards in-flight words. Discarded words are not counted.

## Structure
- Package hamming_pkg holds:
  - DATA_W=16, CODE_W=21, SYN_W=5
  - localparam array DATA_POS[16] (the Hamming positions above)
  - parity-group masks P_MASK[5] as 16-bit constants
- Combinational sub-module hamming_syndrome (ham_in → syndrome). It is reused by the link checker later.
- Correction decode, pipeline registers and counters live in the top.

## Test plan
- 0x000000 and 0x1FFFEF (the encoding of 0xFFFF) back-to-back, out_ready=1 → data 0x0000 then 0xFFFF, syndrome 0, no flags, 2-cycle latency, one word per clock.
- 0x000020 (d0 flipped) → data 0x0000, syndrome 3, corrected=1, corr_cnt=1. 0x1FFFFF (p0 flipped) → data 0xFFFF, syndrome 1, corrected=1, corr_cnt=2.
- 0x100020 (d15 and d0 flipped) → data 0x8001, syndrome 22, uncorrectable=1, unc_cnt=1.
- Hold out_ready=0 for 5 cycles while streaming:
  - out_valid stays asserted with its payload stable.
  - in_ready drops after 2 words are accepted.
  - No word is lost or duplicated after release.
- CNT_W=2 with 5 corrected words → corr_cnt saturates at 3. clr_cnt in the same cycle as a corrected transfer → corr_cnt=0.
- rst asserted with both stages full → the next cycle shows out_valid=0, both counters 0 and in_ready=1.
